// File: rtl/csr_exc_pipe.sv
// csr_exc_pipe
//   EX-to-WB pipeline for CSR-write, ERTN and exception sideband state of the
//   dual-issue core. LANES issue lanes travel through STAGES register stages.
//   The last stage is the registered commit record. It resolves per-lane
//   exceptions so that the oldest excepting lane wins, and it suppresses the
//   CSR write of that lane and of any younger lane.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   stall            hold every stage (outputs and counter included)
//   kill_mask        per-lane entry kill; a killed lane enters as a bubble
//   in_valid/in_exc/in_ecode/in_badv_we/in_badv/in_pc
//                    per-lane instruction state, lane i at slice i
//   in_csr_lane      lane owning the CSR op / ERTN
//   in_csr_waddr/in_csr_wmask/in_csr_wdata/in_ertn
//                    CSR write request of the owning lane
//   out_valid        committed lanes
//   out_csr_*        committed CSR write, mask zeroed when suppressed
//   out_ertn         committed ERTN
//   out_exc/out_ecode/out_badv_we/out_badv/out_era
//                    winning exception record
//   out_flush        one-cycle flush request, clears the whole pipe
//   out_exc_cnt      saturating committed-exception counter
module csr_exc_pipe #(
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int ECW    = 7,
  parameter int CNTW   = 16,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  stall,
  input  logic [LANES-1:0]      kill_mask,
  input  logic [LANES-1:0]      in_valid,
  input  logic [LANES-1:0]      in_exc,
  input  logic [LANES*ECW-1:0]  in_ecode,
  input  logic [LANES-1:0]      in_badv_we,
  input  logic [LANES*32-1:0]   in_badv,
  input  logic [LANES*32-1:0]   in_pc,
  input  logic [LW-1:0]         in_csr_lane,
  input  logic [13:0]           in_csr_waddr,
  input  logic [31:0]           in_csr_wmask,
  input  logic [31:0]           in_csr_wdata,
  input  logic                  in_ertn,
  output logic [LANES-1:0]      out_valid,
  output logic [13:0]           out_csr_waddr,
  output logic [31:0]           out_csr_wmask,
  output logic [31:0]           out_csr_wdata,
  output logic                  out_ertn,
  output logic                  out_exc,
  output logic [ECW-1:0]        out_ecode,
  output logic                  out_badv_we,
  output logic [31:0]           out_badv,
  output logic [31:0]           out_era,
  output logic                  out_flush,
  output logic [CNTW-1:0]       out_exc_cnt
);

  // Internal stages before the commit register.
  localparam int MID = STAGES - 1;

  typedef struct packed {
    logic [LANES-1:0]     vld;
    logic [LANES-1:0]     exc;
    logic [LANES*ECW-1:0] ecode;
    logic [LANES-1:0]     badv_we;
    logic [LANES*32-1:0]  badv;
    logic [LANES*32-1:0]  pc;
    logic [LW-1:0]        csr_lane;
    logic [13:0]          csr_waddr;
    logic [31:0]          csr_wmask;
    logic [31:0]          csr_wdata;
    logic                 ertn;
  } stage_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // ---------------- stage p0: entry filtering ----------------
  stage_t           cap_p0;
  logic [LANES-1:0] lane_ok;
  logic             own_ok;

  always_comb begin
    lane_ok        = in_valid & ~kill_mask;
    cap_p0         = '0;
    cap_p0.vld     = lane_ok;
    cap_p0.exc     = in_exc & lane_ok;
    cap_p0.badv_we = in_badv_we & lane_ok;
    // Payload of dead lanes is zeroed so stale data never reaches the CSR file.
    for (int i = 0; i < LANES; i++) begin
      if (lane_ok[i]) begin
        cap_p0.ecode[i*ECW +: ECW] = in_ecode[i*ECW +: ECW];
        cap_p0.badv[i*32 +: 32]    = in_badv[i*32 +: 32];
        cap_p0.pc[i*32 +: 32]      = in_pc[i*32 +: 32];
      end
    end
    // An owner index beyond LANES-1 never matches, so it counts as dead.
    own_ok = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (int'(in_csr_lane) == i) own_ok = lane_ok[i];
    end
    cap_p0.csr_lane  = in_csr_lane;
    cap_p0.csr_waddr = in_csr_waddr;
    cap_p0.csr_wdata = in_csr_wdata;
    cap_p0.csr_wmask = own_ok ? in_csr_wmask : '0;
    cap_p0.ertn      = own_ok & in_ertn;
  end

  // ---------------- stages p0..p(STAGES-2): delay chain ----------------
  stage_t stg_p [MID];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < MID; k++) stg_p[k] <= '0;
    end else if (out_flush) begin
      for (int k = 0; k < MID; k++) stg_p[k] <= '0;
    end else if (!stall) begin
      stg_p[0] <= cap_p0;
      for (int k = 1; k < MID; k++) stg_p[k] <= stg_p[k-1];
    end
  end

  // ---------------- final stage: exception resolve ----------------
  stage_t           last;
  logic [LANES-1:0] r_valid;
  logic             r_exc;
  logic [LW-1:0]    r_win;
  logic [ECW-1:0]   r_ecode;
  logic             r_badv_we;
  logic [31:0]      r_badv;
  logic [31:0]      r_era;
  logic [31:0]      r_wmask;
  logic             r_ertn;

  assign last = stg_p[MID-1];

  always_comb begin
    r_valid   = last.vld;
    r_exc     = 1'b0;
    r_win     = '0;
    r_ecode   = '0;
    r_badv_we = 1'b0;
    r_badv    = '0;
    r_era     = '0;
    r_wmask   = last.csr_wmask;
    r_ertn    = last.ertn;
    // Scan youngest to oldest so the oldest excepting lane is the one kept.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (last.vld[i] && last.exc[i]) begin
        r_exc     = 1'b1;
        r_win     = LW'(i);
        r_ecode   = last.ecode[i*ECW +: ECW];
        r_badv_we = last.badv_we[i];
        r_badv    = last.badv[i*32 +: 32];
        r_era     = last.pc[i*32 +: 32];
      end
    end
    if (r_exc) begin
      for (int i = 0; i < LANES; i++) begin
        if (i >= int'(r_win)) r_valid[i] = 1'b0;
      end
      // The winner and every younger lane are squashed, CSR side effects too.
      if (last.csr_lane >= r_win) begin
        r_wmask = '0;
        r_ertn  = 1'b0;
      end
    end
  end

  // ---------------- commit register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || out_flush) begin
      out_valid     <= '0;
      out_csr_waddr <= '0;
      out_csr_wmask <= '0;
      out_csr_wdata <= '0;
      out_ertn      <= 1'b0;
      out_exc       <= 1'b0;
      out_ecode     <= '0;
      out_badv_we   <= 1'b0;
      out_badv      <= '0;
      out_era       <= '0;
      out_flush     <= 1'b0;
    end else if (!stall) begin
      out_valid     <= r_valid;
      out_csr_waddr <= last.csr_waddr;
      out_csr_wmask <= r_wmask;
      out_csr_wdata <= last.csr_wdata;
      out_ertn      <= r_ertn;
      out_exc       <= r_exc;
      out_ecode     <= r_ecode;
      out_badv_we   <= r_badv_we;
      out_badv      <= r_badv;
      out_era       <= r_era;
      out_flush     <= r_exc | r_ertn;
    end
  end

  // The counter survives flushes; it only moves on a normal advance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_exc_cnt <= '0;
    end else if (!out_flush && !stall && r_exc) begin
      out_exc_cnt <= sat_inc(out_exc_cnt);
    end
  end

endmodule

// File: tb/tb_csr_exc_pipe.sv
module tb_csr_exc_pipe;
  localparam int L   = 2;
  localparam int S   = 3;
  localparam int ECW = 7;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic stall;
  logic [L-1:0]     kill_mask, in_valid, in_exc, in_badv_we;
  logic [L*ECW-1:0] in_ecode;
  logic [L*32-1:0]  in_badv, in_pc;
  logic [0:0]       in_csr_lane;
  logic [13:0]      in_csr_waddr;
  logic [31:0]      in_csr_wmask, in_csr_wdata;
  logic             in_ertn;

  logic [L-1:0]   d_valid;
  logic [13:0]    d_waddr;
  logic [31:0]    d_wmask, d_wdata, d_badv, d_era;
  logic           d_ertn, d_exc, d_badv_we, d_flush;
  logic [ECW-1:0] d_ecode;
  logic [CW-1:0]  d_cnt;

  logic [L-1:0]   c_valid;
  logic [13:0]    c_waddr;
  logic [31:0]    c_wmask, c_wdata, c_badv, c_era;
  logic           c_ertn, c_exc, c_badv_we, c_flush;
  logic [ECW-1:0] c_ecode;
  logic [1:0]     c_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csr_exc_pipe #(.LANES(L), .STAGES(S), .ECW(ECW), .CNTW(CW)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .kill_mask(kill_mask),
    .in_valid(in_valid), .in_exc(in_exc), .in_ecode(in_ecode),
    .in_badv_we(in_badv_we), .in_badv(in_badv), .in_pc(in_pc),
    .in_csr_lane(in_csr_lane), .in_csr_waddr(in_csr_waddr),
    .in_csr_wmask(in_csr_wmask), .in_csr_wdata(in_csr_wdata), .in_ertn(in_ertn),
    .out_valid(d_valid), .out_csr_waddr(d_waddr), .out_csr_wmask(d_wmask),
    .out_csr_wdata(d_wdata), .out_ertn(d_ertn), .out_exc(d_exc),
    .out_ecode(d_ecode), .out_badv_we(d_badv_we), .out_badv(d_badv),
    .out_era(d_era), .out_flush(d_flush), .out_exc_cnt(d_cnt)
  );

  csr_exc_pipe #(.LANES(L), .STAGES(2), .ECW(ECW), .CNTW(2)) dut_c2 (
    .clk(clk), .rstn(rstn), .stall(stall), .kill_mask(kill_mask),
    .in_valid(in_valid), .in_exc(in_exc), .in_ecode(in_ecode),
    .in_badv_we(in_badv_we), .in_badv(in_badv), .in_pc(in_pc),
    .in_csr_lane(in_csr_lane), .in_csr_waddr(in_csr_waddr),
    .in_csr_wmask(in_csr_wmask), .in_csr_wdata(in_csr_wdata), .in_ertn(in_ertn),
    .out_valid(c_valid), .out_csr_waddr(c_waddr), .out_csr_wmask(c_wmask),
    .out_csr_wdata(c_wdata), .out_ertn(c_ertn), .out_exc(c_exc),
    .out_ecode(c_ecode), .out_badv_we(c_badv_we), .out_badv(c_badv),
    .out_era(c_era), .out_flush(c_flush), .out_exc_cnt(c_cnt)
  );

  typedef struct packed {
    logic [L-1:0]   valid;
    logic [13:0]    waddr;
    logic [31:0]    wmask;
    logic [31:0]    wdata;
    logic           ertn;
    logic           exc;
    logic [ECW-1:0] ecode;
    logic           badv_we;
    logic [31:0]    badv;
    logic [31:0]    era;
    logic           flush;
  } out_t;

  typedef struct packed {
    logic [L-1:0]            v;
    logic [L-1:0]            exc;
    logic [L-1:0][ECW-1:0]   ecode;
    logic [L-1:0]            bwe;
    logic [L-1:0][31:0]      badv;
    logic [L-1:0][31:0]      pc;
    logic [7:0]              lane;
    logic [13:0]             waddr;
    logic [31:0]             wmask;
    logic [31:0]             wdata;
    logic                    ertn;
  } rec_t;

  out_t act;
  assign act = {d_valid, d_waddr, d_wmask, d_wdata, d_ertn, d_exc, d_ecode,
                d_badv_we, d_badv, d_era, d_flush};

  // Reference model: a queue of accepted instruction groups and the commit
  // record computed from them by the oldest-exception-wins rule.
  rec_t          m_pend[$];
  out_t          m_out;
  logic [CW-1:0] m_cnt;

  function automatic rec_t capture();
    rec_t r;
    r = '0;
    for (int i = 0; i < L; i++) begin
      if (in_valid[i] && !kill_mask[i]) begin
        r.v[i]     = 1'b1;
        r.exc[i]   = in_exc[i];
        r.bwe[i]   = in_badv_we[i];
        r.ecode[i] = in_ecode[i*ECW +: ECW];
        r.badv[i]  = in_badv[i*32 +: 32];
        r.pc[i]    = in_pc[i*32 +: 32];
      end
    end
    r.lane  = 8'(in_csr_lane);
    r.waddr = in_csr_waddr;
    r.wdata = in_csr_wdata;
    if (r.v[in_csr_lane]) begin
      r.wmask = in_csr_wmask;
      r.ertn  = in_ertn;
    end
    return r;
  endfunction

  function automatic out_t resolve(input rec_t r);
    out_t o;
    int w;
    o = '0;
    w = -1;
    for (int i = 0; i < L; i++) if (w < 0 && r.v[i] && r.exc[i]) w = i;
    o.valid = r.v;
    o.waddr = r.waddr;
    o.wdata = r.wdata;
    o.wmask = r.wmask;
    o.ertn  = r.ertn;
    if (w >= 0) begin
      for (int i = w; i < L; i++) o.valid[i] = 1'b0;
      o.exc     = 1'b1;
      o.ecode   = r.ecode[w];
      o.badv_we = r.bwe[w];
      o.badv    = r.badv[w];
      o.era     = r.pc[w];
      if (int'(r.lane) >= w) begin
        o.wmask = '0;
        o.ertn  = 1'b0;
      end
    end
    o.flush = o.exc | o.ertn;
    return o;
  endfunction

  function automatic void model_reset();
    m_pend.delete();
    for (int i = 0; i < S - 1; i++) m_pend.push_back('0);
    m_out = '0;
    m_cnt = '0;
  endfunction

  function automatic void model_edge();
    rec_t r;
    if (m_out.flush) begin
      m_pend.delete();
      for (int i = 0; i < S - 1; i++) m_pend.push_back('0);
      m_out = '0;
    end else if (!stall) begin
      r = m_pend.pop_front();
      m_out = resolve(r);
      m_pend.push_back(capture());
      if (m_out.exc && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rstn) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; kill_mask = 0; in_valid = 0; in_exc = 0; in_ecode = 0;
    in_badv_we = 0; in_badv = 0; in_pc = 0; in_csr_lane = 0;
    in_csr_waddr = 0; in_csr_wmask = 0; in_csr_wdata = 0; in_ertn = 0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (S + 2) tick();
  endtask

  task automatic test_reset();
    drain();
    in_valid = 2'b01; in_exc = 2'b01; in_ecode = {7'h00, 7'h11};
    tick();
    idle_inputs();
    repeat (S - 1) tick();
    total++; if (d_cnt !== 16'd1) begin bad++; $display("FAIL rst_pre_cnt: got %0d want 1", d_cnt); end
    in_valid = 2'b11; in_csr_wdata = 32'h0BAD_F00D;
    #2 rstn = 0;
    #1;
    model_reset();
    total++; if (act !== '0) begin bad++; $display("FAIL rst_outputs: got %h want 0", act); end
    total++; if (d_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", d_cnt); end
    tick(); tick();
    rstn = 1;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (d_valid !== 2'b00) begin bad++; $display("FAIL idle_valid: got %b want 00", d_valid); end
    end
    in_valid = 2'b01; in_csr_wdata = 32'h77;
    tick();
    idle_inputs();
    for (int k = 0; k < S - 2; k++) begin
      tick();
      total++; if (d_valid !== 2'b00) begin bad++; $display("FAIL post_rst_early: got %b want 00", d_valid); end
    end
    tick();
    total++; if (d_valid !== 2'b01 || d_wdata !== 32'h77) begin
      bad++; $display("FAIL post_rst_first: got valid=%b wdata=%h want 01/77", d_valid, d_wdata);
    end
  endtask

  task automatic test_clean_csr();
    drain();
    in_valid = 2'b10; in_csr_lane = 1'b1; in_csr_waddr = 14'h0006;
    in_csr_wmask = 32'hFFFF_FFFF; in_csr_wdata = 32'h1234;
    tick();
    idle_inputs();
    repeat (S - 2) tick();
    tick();
    total++; if (d_valid !== 2'b10) begin bad++; $display("FAIL csr_valid: got %b want 10", d_valid); end
    total++; if (d_waddr !== 14'h0006 || d_wmask !== 32'hFFFF_FFFF || d_wdata !== 32'h1234) begin
      bad++; $display("FAIL csr_write: got %h/%h/%h want 0006/ffffffff/00001234", d_waddr, d_wmask, d_wdata);
    end
    total++; if (d_exc !== 1'b0 || d_flush !== 1'b0) begin
      bad++; $display("FAIL csr_noexc: got exc=%b flush=%b want 0/0", d_exc, d_flush);
    end
    tick();
    total++; if (d_valid !== 2'b00) begin bad++; $display("FAIL csr_single: got %b want 00", d_valid); end
  endtask

  task automatic test_oldest_exc();
    drain();
    in_valid = 2'b11; in_exc = 2'b11; in_ecode = {7'h0B, 7'h08};
    in_pc = {32'h1C00_0104, 32'h1C00_0100}; in_badv_we = 2'b01;
    in_badv = {32'h0, 32'hDEAD_0000};
    in_csr_lane = 1'b1; in_csr_waddr = 14'h7; in_csr_wmask = 32'hFF; in_csr_wdata = 32'h55;
    tick();
    idle_inputs();
    repeat (S - 2) tick();
    tick();
    total++; if (d_exc !== 1'b1 || d_ecode !== 7'h08 || d_era !== 32'h1C00_0100) begin
      bad++; $display("FAIL exc_winner: got exc=%b ecode=%h era=%h want 1/08/1c000100", d_exc, d_ecode, d_era);
    end
    total++; if (d_badv_we !== 1'b1 || d_badv !== 32'hDEAD_0000) begin
      bad++; $display("FAIL exc_badv: got %b/%h want 1/dead0000", d_badv_we, d_badv);
    end
    total++; if (d_valid !== 2'b00 || d_wmask !== 32'h0 || d_waddr !== 14'h7) begin
      bad++; $display("FAIL exc_squash: got valid=%b wmask=%h waddr=%h want 00/0/7", d_valid, d_wmask, d_waddr);
    end
    total++; if (d_flush !== 1'b1 || d_cnt !== 16'd1) begin
      bad++; $display("FAIL exc_flush_cnt: got flush=%b cnt=%0d want 1/1", d_flush, d_cnt);
    end
    tick();
    total++; if (act !== '0 || d_cnt !== 16'd1) begin
      bad++; $display("FAIL exc_after_flush: got %h cnt=%0d want 0 cnt=1", act, d_cnt);
    end
  endtask

  task automatic test_kill();
    drain();
    in_valid = 2'b11; kill_mask = 2'b10; in_exc = 2'b10; in_ecode = {7'h05, 7'h00};
    in_csr_lane = 1'b0; in_csr_wmask = 32'h0F;
    tick();
    idle_inputs();
    repeat (S - 1) tick();
    total++; if (d_exc !== 1'b0 || d_valid !== 2'b01 || d_flush !== 1'b0 || d_wmask !== 32'h0F) begin
      bad++; $display("FAIL kill_lane1: got exc=%b valid=%b flush=%b wmask=%h want 0/01/0/f", d_exc, d_valid, d_flush, d_wmask);
    end
    in_valid = 2'b11; kill_mask = 2'b10; in_csr_lane = 1'b1; in_csr_wmask = 32'hF0; in_ertn = 1'b1;
    tick();
    idle_inputs();
    repeat (S - 1) tick();
    total++; if (d_wmask !== 32'h0 || d_ertn !== 1'b0 || d_valid !== 2'b01) begin
      bad++; $display("FAIL kill_owner: got wmask=%h ertn=%b valid=%b want 0/0/01", d_wmask, d_ertn, d_valid);
    end
  endtask

  task automatic test_stall_flush();
    drain();
    in_valid = 2'b01; in_csr_wmask = 32'h1; in_csr_wdata = 32'hAAAA;
    tick();
    in_csr_wdata = 32'hBBBB;
    tick();
    idle_inputs();
    repeat (S - 2) tick();
    total++; if (d_wdata !== 32'hAAAA) begin bad++; $display("FAIL stall_pre: got %h want aaaa", d_wdata); end
    stall = 1; in_valid = 2'b11; in_csr_wdata = 32'h5555;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (d_wdata !== 32'hAAAA || d_valid !== 2'b01) begin
        bad++; $display("FAIL stall_hold: got wdata=%h valid=%b want aaaa/01", d_wdata, d_valid);
      end
    end
    idle_inputs();
    tick();
    total++; if (d_wdata !== 32'hBBBB || d_valid !== 2'b01) begin
      bad++; $display("FAIL stall_release: got wdata=%h valid=%b want bbbb/01", d_wdata, d_valid);
    end
    tick();
    total++; if (d_valid !== 2'b00) begin bad++; $display("FAIL stall_nodup: got %b want 00", d_valid); end

    drain();
    in_valid = 2'b01; in_exc = 2'b01; in_ecode = {7'h00, 7'h03};
    tick();
    in_exc = 2'b00; in_ecode = 0; in_csr_wdata = 32'hBBBB;
    tick();
    in_csr_wdata = 32'hCCCC;
    repeat (S - 2) tick();
    total++; if (d_flush !== 1'b1 || d_ecode !== 7'h03) begin
      bad++; $display("FAIL sf_flush: got flush=%b ecode=%h want 1/03", d_flush, d_ecode);
    end
    stall = 1; in_csr_wdata = 32'hDDDD;
    tick();
    total++; if (act !== '0) begin bad++; $display("FAIL sf_clear: got %h want 0", act); end
    tick();
    total++; if (act !== '0) begin bad++; $display("FAIL sf_clear_hold: got %h want 0", act); end
    idle_inputs();
    for (int k = 0; k < S; k++) begin
      tick();
      total++; if (d_valid !== 2'b00) begin bad++; $display("FAIL sf_discard: got %b want 00", d_valid); end
    end
  endtask

  task automatic test_random();
    drain();
    for (int n = 0; n < 500; n++) begin
      in_valid     = L'($urandom);
      kill_mask    = L'($urandom & $urandom);
      in_exc       = ($urandom_range(0, 2) == 0) ? L'($urandom) : '0;
      in_ecode     = (L*ECW)'($urandom);
      in_badv_we   = L'($urandom);
      in_badv      = {$urandom, $urandom};
      in_pc        = {$urandom, $urandom};
      in_csr_lane  = 1'($urandom);
      in_csr_waddr = 14'($urandom);
      in_csr_wmask = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      in_csr_wdata = $urandom;
      in_ertn      = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      tick();
      total++; if (act !== m_out) begin bad++; $display("FAIL rnd_out @%0d: got %h want %h", n, act, m_out); end
      total++; if (d_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, d_cnt, m_cnt); end
    end
    drain();
  endtask

  task automatic test_cnt_sat();
    idle_inputs();
    #2 rstn = 0;
    #1 model_reset();
    tick();
    rstn = 1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 2'b01; in_exc = 2'b01;
      tick();
      idle_inputs();
      tick();
      total++; if (c_cnt !== 2'((k > 3) ? 3 : k)) begin
        bad++; $display("FAIL cnt_sat k=%0d: got %0d want %0d", k, c_cnt, (k > 3) ? 3 : k);
      end
      tick();
    end
    repeat (S) tick();
    total++; if (c_cnt !== 2'd3 || d_cnt !== m_cnt) begin
      bad++; $display("FAIL cnt_final: got %0d/%0d want 3/%0d", c_cnt, d_cnt, m_cnt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    model_reset();
    repeat (3) tick();
    rstn = 1;
    test_reset();
    test_clean_csr();
    test_oldest_exc();
    test_kill();
    test_stall_flush();
    test_random();
    test_cnt_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_exc_pipe.md
# csr_exc_pipe

Parametrised EX-to-WB pipeline for CSR-write, ERTN and exception sideband state in the dual-issue core. It carries LANES issue lanes through STAGES register stages, and holds or clears all stages on stall, branch-mispredict kill and commit flush. In its final stage it resolves per-lane exceptions into one oldest-lane-wins commit record for the CSR file. It also counts committed exceptions.

## Interface
- LANES, 2, issue lanes; lane 0 is oldest (range 1..4)
- STAGES, 2, register stages from EX output to commit output (range 2..4)
- ECW, 7, exception code width
- CNTW, 16, committed-exception counter width
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, asynchronous active-low
- stall  in  1  holds every stage, including outputs, when high (dcache or divider stall)
- kill_mask  in  LANES  per-lane kill at pipeline entry (branch mispredict); a set bit enters that lane as a bubble
- in_valid  in  LANES  lane carries an instruction
- in_exc  in  LANES  lane raised an exception
- in_ecode  in  LANES*ECW  per-lane exception code, lane i at [i*ECW +: ECW]
- in_badv_we  in  LANES  lane has a bad virtual address
- in_badv  in  LANES*32  per-lane bad address
- in_pc  in  LANES*32  per-lane PC
- in_csr_lane  in  $clog2(LANES) (min 1)  lane owning the CSR op
- in_csr_waddr  in  14  CSR address
- in_csr_wmask  in  32  CSR bit write mask; 0 = no write
- in_csr_wdata  in  32  CSR write data
- in_ertn  in  1  CSR-owning lane is ERTN
- out_valid  out  LANES  committed lanes
- out_csr_waddr  out  14  committed CSR address
- out_csr_wmask  out  32  committed CSR write mask, after suppression
- out_csr_wdata  out  32  committed CSR write data
- out_ertn  out  1  committed ERTN
- out_exc  out  1  exception committed
- out_ecode  out  ECW  winning exception code
- out_badv_we  out  1  winning lane's badv write enable
- out_badv  out  32  winning lane's bad address
- out_era  out  32  winning lane's PC
- out_flush  out  1  registered, one-cycle pipeline flush request
- out_exc_cnt  out  CNTW  saturating count of committed exceptions

## Operation
- Stage 0 captures the inputs. Lane i is stored as valid only if in_valid[i] and !kill_mask[i].
  - When lane i is killed or invalid, its exc, badv_we and payload are stored as 0.
  - When the CSR-owning lane is killed or invalid, the stored CSR mask and ertn are 0.
- Stages 1..STAGES-2 copy the previous stage unchanged.
- The final stage (outputs) is loaded through the resolve logic:
  - Winner w = lowest-index lane that is valid with exc set; "none" if no such lane.
  - If w exists:
    - out_valid keeps lanes < w and sets lanes > w and lane w to 0.
    - out_exc=1; out_ecode, out_badv, out_badv_we and out_era come from lane w.
    - If csr_lane >= w, out_csr_wmask=0 and out_ertn=0.
  - If no winner: out_exc=0; ecode, badv, badv_we and era are 0; CSR fields and valids pass through.
- out_flush is loaded with (resolved out_exc | resolved out_ertn).
- out_exc_cnt increments by 1 when the final stage loads with out_exc=1. It saturates at all-ones.
- Priority of stage updates on each edge, highest first:
  1. Reset.
  2. out_flush=1: every stage and every output except out_exc_cnt is cleared to 0, so out_flush returns to 0.
  3. stall=1: every stage holds, including out_flush and the counter.
  4. Normal advance.
- A flush takes precedence over a simultaneous stall. Inputs presented in the flush cycle are discarded.

## Timing
- Reset (rstn low, asynchronous): all stages, all outputs and out_exc_cnt are 0.
- Latency: inputs accepted at edge N appear on the outputs after edge N+STAGES-1 with no stall.
- Each stall cycle adds exactly one cycle of latency. No data is lost or duplicated.
- out_flush is high for exactly one non-stalled cycle. If a stall is active when out_flush rises, the flush still clears everything at the next edge.
- Releasing rstn mid-stream: the first valid output appears STAGES-1 edges after the first accepted input.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset and idle: assert rstn=0 mid-stream -> all outputs and out_exc_cnt become 0 immediately; with no valid input, out_valid stays 0.
- Clean CSR write: lane1 valid, csr_lane=1, waddr=0x0006, wmask=0xFFFFFFFF, wdata=0x1234 -> the same values appear STAGES-1 edges later; out_exc=0, out_flush=0.
- Oldest-lane exception: lane0 exc ecode=0x08, pc=0x1C000100; lane1 exc ecode=0x0B, csr_lane=1, wmask=0xFF -> out_exc=1, out_ecode=0x08, out_era=0x1C000100, out_valid=0, out_csr_wmask=0, out_flush=1 for one cycle, then all outputs 0; counter increments to 1.
- Kill at entry: kill_mask=2'b10 with lane1 exc=1 -> out_exc=0, out_valid=2'b01.
- Stall plus flush: stall=1 held for 3 cycles mid-stream -> outputs frozen. Stall asserted in the cycle out_flush=1 -> stages still cleared on the next edge.
- Counter saturation: CNTW=2, commit 5 exceptions -> out_exc_cnt stops at 3.
